// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath types and Q-format constants
//
// Purpose: FSM state encoding for the sequential complex multiplier and the
//          fixed-point format constants used across the FFT datapath.
// Ports:   none (package).
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M_AC = 3'd1,
    M_BD = 3'd2,
    M_AD = 3'd3,
    M_BC = 3'd4,
    DONE = 3'd5
  } cmul_state_t;

  // Default datapath width is Q8.8.
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = DATA_WIDTH / 2;
  localparam int ONE        = 1 << FRAC_BITS;

  // Fraction bits for an arbitrary width in the same Q(W/2).(W/2) format.
  function automatic int frac_bits_of(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/cmplx_mult_seq_mul.sv
// rtl/cmplx_mult_seq_mul.sv - signed fixed-point real multiplier
//
// Purpose: combinational signed WIDTH x WIDTH multiply. The 2*WIDTH product
//          is truncated back to Q(WIDTH/2).(WIDTH/2) by keeping bits
//          [WIDTH+WIDTH/2-1 : WIDTH/2]. No rounding, no saturation.
// Ports:   x, y  in  WIDTH  signed operands
//          p     out WIDTH  truncated product
module cmplx_mult_seq_mul
  import fft_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] p
);

  localparam int FRAC = frac_bits_of(WIDTH);

  logic signed [2*WIDTH-1:0]      full;
  logic        [WIDTH-FRAC-1:0]   unused_hi;
  logic        [FRAC-1:0]         unused_lo;

  assign full = $signed(x) * $signed(y);

  // Dropped high bits are intentional: the format wraps instead of saturating.
  assign {unused_hi, p, unused_lo} = full;

endmodule

// File: rtl/cmplx_mult_seq.sv
// rtl/cmplx_mult_seq.sv - time-shared complex multiplier for the FFT datapath
//
// Purpose: forms (a+jb)*(c+jd) (or times conj(w)) by sequencing ac, bd, ad,
//          bc through one real multiplier and accumulating real/imag parts.
// Ports:   clk, rst_n            clock, async active-low reset
//          in_valid / in_ready   operand handshake (ready only in IDLE)
//          a_re, a_im            data operand (a, b)
//          w_re, w_im            twiddle operand (c, d)
//          conj                  1: use conj(w)
//          out_valid / out_ready result handshake, held under backpressure
//          y_re, y_im            complex product
//          busy                  high whenever not IDLE
module cmplx_mult_seq
  import fft_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] w_re,
  input  logic [WIDTH-1:0] w_im,
  input  logic             conj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_re,
  output logic [WIDTH-1:0] y_im,
  output logic             busy
);

  cmul_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic             conj_q;
  logic [WIDTH-1:0] acc_re, acc_im;
  logic [WIDTH-1:0] mul_x, mul_y, mul_p;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = M_AC;
        end
      end
      M_AC: state_d = M_BD;
      M_BD: state_d = M_AD;
      M_AD: state_d = M_BC;
      M_BC: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: the multiplier only ever sees these registered copies,
  // so the input ports are free to change once the handshake has happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      conj_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q    <= a_re;
      b_q    <= a_im;
      c_q    <= w_re;
      d_q    <= w_im;
      conj_q <= conj;
    end
  end

  // Operand muxes: x is a in AC/AD, otherwise b; y is c in AC/BC, otherwise d.
  always_comb begin
    mul_x = b_q;
    mul_y = d_q;
    if (state_q == M_AC || state_q == M_AD) begin
      mul_x = a_q;
    end
    if (state_q == M_AC || state_q == M_BC) begin
      mul_y = c_q;
    end
  end

  cmplx_mult_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (mul_p)
  );

  // Accumulators. With conj the sign of d flips, which turns the bd term into
  // an add and the ad term (already sitting in acc_im) into a subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      case (state_q)
        M_AC: acc_re <= mul_p;
        M_BD: acc_re <= conj_q ? (acc_re + mul_p) : (acc_re - mul_p);
        M_AD: acc_im <= mul_p;
        M_BC: acc_im <= conj_q ? (mul_p - acc_im) : (mul_p + acc_im);
        default: ;
      endcase
    end
  end

  assign y_re = acc_re;
  assign y_im = acc_im;

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// tb/tb_cmplx_mult_seq.sv - directed self-checking bench for cmplx_mult_seq
module tb_cmplx_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_re, a_im, w_re, w_im;
  logic        conj;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y_re, y_im;
  logic        busy;

  int n_tests;
  int n_fail;

  cmplx_mult_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .conj      (conj),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_re      (y_re),
    .y_im      (y_im),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one operand set from IDLE, then check latency and result.
  // Leaves the bench at the negedge of the first DONE cycle.
  task automatic run_op(input string tag, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] wr, input logic [15:0] wi, input logic cj,
                        input logic [15:0] er, input logic [15:0] ei);
    int cyc;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    a_re = ar; a_im = ai; w_re = wr; w_im = wi; conj = cj;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a_re = 16'hDEAD; a_im = 16'hBEEF; w_re = 16'h1234; w_im = 16'h5678; conj = ~cj;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_y_re"}, y_re, er);
    check({tag, "_y_im"}, y_im, ei);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_re = '0; a_im = '0; w_re = '0; w_im = '0; conj = 1'b0;

    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_y", {y_re, y_im}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // (1+j2)*(3+j0.5) = 2 + j6.5 ; times conj -> 4 + j5.5
    run_op("t1", 16'h0100, 16'h0200, 16'h0300, 16'h0080, 1'b0, 16'h0200, 16'h0680);
    step();
    check("t1_back_idle", in_ready, 1'b1);
    run_op("t2", 16'h0100, 16'h0200, 16'h0300, 16'h0080, 1'b1, 16'h0400, 16'h0580);
    step();
    // (-1)*(j1) = -j1
    run_op("t3", 16'hFF00, 16'h0000, 16'h0000, 16'h0100, 1'b0, 16'h0000, 16'hFF00);
    step();

    // Backpressure: result must be held and a pulsed in_valid ignored.
    out_ready = 1'b0;
    run_op("t4", 16'h0200, 16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0100, 16'h0300);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_y", {y_re, y_im}, 32'h0100_0300);
      check("t4_hold_in_ready", in_ready, 1'b0);
      in_valid = (i == 3);
      a_re = 16'h0500; a_im = 16'h0500; w_re = 16'h0500; w_im = 16'h0500;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("t4_release_in_ready", in_ready, 1'b1);
    check("t4_release_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 7; i++) step();
    check("t4_ignored_busy", busy, 1'b0);
    check("t4_ignored_y", {y_re, y_im}, 32'h0100_0300);

    // Wrap: 127.0 * 2.0 truncates to 0xFE00.
    run_op("t5", 16'h7F00, 16'h0000, 16'h0200, 16'h0000, 1'b0, 16'hFE00, 16'h0000);
    step();

    // Reset while in M_AD abandons the product.
    a_re = 16'h0100; a_im = 16'h0200; w_re = 16'h0300; w_im = 16'h0080; conj = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("t6_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_in_ready", in_ready, 1'b1);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_y", {y_re, y_im}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_no_output", out_valid, 1'b0);
    run_op("t6_after", 16'h0100, 16'h0200, 16'h0300, 16'h0080, 1'b1, 16'h0400, 16'h0580);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
